// File: rtl/instr_fetch.sv
// Fetch stage: issues one req/ready read per pc, presents the word to if_id,
// and drives pc write-enable with stall, flush, misalign and timeout handling.
module instr_fetch #(
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        idStall,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic [31:0] instruction,
  output logic        valid,
  output logic [31:0] pcIncr,
  output logic        pcWe,
  output logic        fetchErr
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we;

  logic       timeout;
  logic [7:0] cnt_inc;

  assign timeout = (cnt_q == TMO);
  assign cnt_inc = timeout ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (flush) begin
          we = 1'b1;
        end else if (pc[1:0] != 2'b00) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          req_d   = 1'b1;
          addr_d  = pc;
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          we      = 1'b1;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (memReady) begin
            req_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_inc;
            state_d = S_DRAIN;
          end
        end else if (memReady) begin
          req_d   = 1'b0;
          instr_d = memData;
          valid_d = 1'b1;
          if (!idStall) begin
            we      = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
          end
        end else if (timeout) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          we      = 1'b1;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (!idStall) begin
          we      = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // the flushed read is still owed by memory; wait it out
        we = flush;
        if (memReady) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else if (timeout) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ERR: begin
        req_d   = 1'b0;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= 32'd0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign memReq      = req_q;
  assign memAddr     = addr_q;
  assign instruction = instr_q;
  assign valid       = valid_q;
  assign fetchErr    = err_q;
  assign pcIncr      = addr_q + 32'd4;
  assign pcWe        = we & ~rst;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        rst, flush, idStall, memReady;
  logic [31:0] pc, tgt;
  logic        memReq, valid, pcWe, fetchErr;
  logic [31:0] memAddr, memData, instruction, pcIncr;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  assign memData = memf(memAddr);

  instr_fetch dut (
    .clock      (clock),
    .rst        (rst),
    .pc         (pc),
    .flush      (flush),
    .idStall    (idStall),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memReady   (memReady),
    .memData    (memData),
    .instruction(instruction),
    .valid      (valid),
    .pcIncr     (pcIncr),
    .pcWe       (pcWe),
    .fetchErr   (fetchErr)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // model: an outstanding read (possibly doomed by a flush), a word
  // waiting on if_id, or a sticky error; otherwise idle
  bit          m_on = 0;
  bit          m_req, m_drop, m_held, m_valid, m_err;
  logic [31:0] m_addr, m_instr;
  int          m_cnt;

  function automatic logic exp_we();
    if (rst || m_err) return 1'b0;
    if (flush) return 1'b1;
    if (m_req && !m_drop && memReady && !idStall) return 1'b1;
    if (m_held && !idStall) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clock) begin
    if (rst) begin
      m_on = 1; m_req = 0; m_drop = 0; m_held = 0;
      m_valid = 0; m_err = 0; m_addr = 0; m_instr = NOP; m_cnt = 0;
    end else if (m_on && !m_err) begin
      if (m_held) begin
        if (flush) begin
          m_held = 0; m_valid = 0; m_instr = NOP;
        end else if (!idStall) begin
          m_held = 0;
        end
      end else if (m_req) begin
        if (memReady) begin
          m_req = 0;
          if (m_drop || flush) begin
            m_drop = 0; m_valid = 0; m_instr = NOP;
          end else begin
            m_instr = memf(m_addr); m_valid = 1; m_held = idStall;
          end
        end else if (flush && !m_drop) begin
          m_drop = 1;
          m_cnt = (m_cnt == 255) ? m_cnt : m_cnt + 1;
        end else if (m_cnt == 255) begin
          m_req = 0; m_err = 1; m_drop = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        m_valid = 0; m_instr = NOP;
        if (!flush) begin
          if (pc[1:0] != 2'b00) begin
            m_err = 1;
          end else begin
            m_req = 1; m_addr = pc; m_cnt = 0;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_on) begin
      chk1("m_memReq", memReq, m_req);
      chk("m_memAddr", memAddr, m_addr);
      chk("m_instr", instruction, m_instr);
      chk1("m_valid", valid, m_valid);
      chk("m_pcIncr", pcIncr, m_addr + 32'd4);
      chk1("m_pcWe", pcWe, exp_we());
      chk1("m_fetchErr", fetchErr, m_err);
    end
  end

  // advance one cycle; the pc register follows pcWe like the real mux
  task automatic tick();
    logic        w;
    logic [31:0] inc;
    @(negedge clock);
    w   = pcWe;
    inc = pcIncr;
    @(posedge clock);
    #1;
    if (w) pc = flush ? tgt : inc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] words [3];
  int cyc;

  initial begin
    words = '{32'h0000_0013, 32'h0000_0413, 32'h0000_0813};
    rst = 1; flush = 0; idStall = 0; memReady = 1; pc = 0; tgt = 0;
    tick(); tick();
    chk1("rst_memReq", memReq, 1'b0);
    chk1("rst_valid", valid, 1'b0);
    chk("rst_instr", instruction, NOP);
    chk1("rst_err", fetchErr, 1'b0);
    chk1("rst_pcWe", pcWe, 1'b0);
    rst = 0;

    // zero-wait stream
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("t1_req", memReq, 1'b1);
      chk("t1_addr", memAddr, 32'(k * 4));
      chk1("t1_we", pcWe, 1'b1);
      tick();
      chk1("t1_valid", valid, 1'b1);
      chk("t1_instr", instruction, words[k]);
      chk1("t1_we_idle", pcWe, 1'b0);
    end

    // three wait cycles
    memReady = 0;
    tick();
    for (int j = 0; j < 3; j++) begin
      chk("t2_addr", memAddr, 32'h0000_000C);
      chk1("t2_we", pcWe, 1'b0);
      tick();
    end
    memReady = 1;
    #1;
    chk1("t2_we_rdy", pcWe, 1'b1);
    tick();
    chk("t2_instr", instruction, 32'h0000_0C13);

    // decode stall across ready
    idStall = 1;
    tick();
    chk1("t3_we_wait", pcWe, 1'b0);
    tick();
    chk1("t3_valid", valid, 1'b1);
    chk("t3_instr", instruction, 32'h0000_1013);
    chk1("t3_we_hold", pcWe, 1'b0);
    tick();
    chk("t3_frozen", instruction, 32'h0000_1013);
    chk1("t3_req", memReq, 1'b0);
    idStall = 0;
    #1;
    chk1("t3_we_rel", pcWe, 1'b1);
    memReady = 0;
    tick();
    chk1("t3_valid_idle", valid, 1'b1);
    tick();
    chk1("t3_valid_clr", valid, 1'b0);
    chk("t3_addr", memAddr, 32'h0000_0014);

    // flush while memory is still busy
    flush = 1; tgt = 32'h0000_0100;
    #1;
    chk1("t4_we", pcWe, 1'b1);
    tick();
    flush = 0;
    #1;
    chk1("t4_we_drain", pcWe, 1'b0);
    chk1("t4_req", memReq, 1'b1);
    chk("t4_addr", memAddr, 32'h0000_0014);
    chk1("t4_valid", valid, 1'b0);
    memReady = 1;
    tick();
    chk1("t4_req_idle", memReq, 1'b0);
    chk1("t4_discard", valid, 1'b0);
    chk("t4_nop", instruction, NOP);
    tick();
    chk("t4_newaddr", memAddr, 32'h0000_0100);
    tick();
    chk("t4_instr", instruction, 32'h0001_0013);

    // misaligned pc
    pc = 32'h0000_0102;
    tick();
    chk1("t5_err", fetchErr, 1'b1);
    chk1("t5_req", memReq, 1'b0);
    flush = 1;
    #1;
    chk1("t5_we_err", pcWe, 1'b0);
    flush = 0;
    tick();
    chk1("t5_sticky", fetchErr, 1'b1);
    rst = 1;
    tick();
    chk1("t5_rst_err", fetchErr, 1'b0);
    rst = 0; pc = 32'h0000_0200; memReady = 0;

    // memory timeout
    cyc = 0;
    while (!fetchErr && cyc < 300) begin
      tick();
      cyc++;
    end
    chk("t5_tmo_cycles", 32'(cyc), 32'd257);
    chk1("t5_tmo_req", memReq, 1'b0);
    rst = 1;
    tick();
    chk1("t5_tmo_rst", fetchErr, 1'b0);
    rst = 0;

    // pcIncr wrap, reset mid-wait
    pc = 32'hFFFF_FFFC;
    tick();
    chk("t6_addr", memAddr, 32'hFFFF_FFFC);
    chk("t6_wrap", pcIncr, 32'h0000_0000);
    rst = 1;
    tick();
    chk1("t6_req", memReq, 1'b0);
    chk1("t6_valid", valid, 1'b0);
    chk("t6_addr0", memAddr, 32'h0000_0000);
    rst = 0; pc = 32'h0000_0040;

    // mixed ready / stall / flush pattern, model-checked
    for (int i = 0; i < 80; i++) begin
      memReady = ((i % 3) != 1);
      idStall  = ((i % 5) == 2);
      flush    = ((i % 11) == 7);
      tgt      = 32'h0000_0300 + 32'(i * 16);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
